// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory BRAM controller.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  localparam logic [3:0]  WE_NONE       = 4'b0000;
  localparam logic [3:0]  WE_WORD       = 4'b1111;
  localparam int          ADDR_W_DEF    = 12;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0000;
endpackage

// File: rtl/dmem_window_check.sv
// Combinational request decode: flags out-of-window addresses and malformed
// read/write combinations. Kept standalone so an MMIO decoder can reuse it.
module dmem_window_check
  import mem_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  output logic        fault
);
  // Only the bits above the RAM's byte span select the window.
  localparam logic [31:0] WIN_MASK = ~((32'h1 << (ADDR_W + 2)) - 32'h1);

  logic in_win;
  logic bad_op;

  assign in_win = ((addr ^ BASE_ADDR) & WIN_MASK) == 32'h0;
  // Exactly one of read / write must be requested.
  assign bad_op = (re && we != WE_NONE) || (!re && we == WE_NONE);
  assign fault  = !in_win || bad_op;
endmodule

// File: rtl/dmem_bram_ctrl.sv
// Single-outstanding data-memory controller sequencing word accesses onto a
// single-port BRAM with fixed read latency; responses on a valid/ready channel.
module dmem_bram_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_W       = ADDR_W_DEF,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_re,
  input  logic [3:0]        req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);
  localparam int CNT_W = 3;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic             fault;

  dmem_window_check #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_win (
    .addr  (req_addr),
    .re    (req_re),
    .we    (req_we),
    .fault (fault)
  );

  assign req_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = fault ? RESP : ISSUE;
      ISSUE:   state_n = wr_q ? RESP : RD_WAIT;
      RD_WAIT: if (cnt == '0) state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered BRAM strobes, latency counter and response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= WE_NONE;
      bram_addr  <= '0;
      bram_din   <= '0;
      cnt        <= '0;
      wr_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (fault) begin
            // Rejected requests never touch the BRAM.
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_rdata <= '0;
          end else begin
            // Legal read has req_we == 0, so req_we drives bram_we directly.
            bram_en   <= 1'b1;
            bram_we   <= req_we;
            bram_addr <= req_addr[ADDR_W+1:2];
            bram_din  <= req_wdata;
            wr_q      <= (req_we != WE_NONE);
          end
        end
        ISSUE: begin
          bram_en <= 1'b0;
          bram_we <= WE_NONE;
          if (wr_q) begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
          end else begin
            cnt <= CNT_W'(READ_LATENCY - 1);
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= bram_dout;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/dmem_bram_ctrl.md
Name: dmem_bram_ctrl

Overview:
- Data-memory controller directly downstream of the load/store byte-lane stage.
- Accepts one word-aligned request per transaction over a valid/ready handshake: 4-bit byte-lane write enable, pre-shifted write data, or a read.
- Sequences the access onto a single-port block RAM with fixed read latency, then returns the raw 32-bit word, or a write acknowledge, over a valid/ready response channel.
- While it is busy, it holds the pipeline with req_ready low.

Parameters:
- ADDR_W, 12: word-address width of the BRAM (4096 words, 16 KiB).
- READ_LATENCY, 2: BRAM clock cycles from bram_en to a valid bram_dout; legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte base of the RAM window; only bits [31:ADDR_W+2] are compared.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_re  in  1  read request
- req_we  in  4  byte-lane write enable; non-zero means write
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  lane-positioned write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  read word; 0 for writes and faults
- resp_fault  out  1  out-of-window or illegal request
- bram_en  out  1  BRAM enable
- bram_we  out  4  BRAM byte write enable
- bram_addr  out  ADDR_W  BRAM word address = req_addr[ADDR_W+1:2]
- bram_din  out  32  BRAM write data
- bram_dout  in  32  BRAM read data

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0; bram_en=0; bram_we=0; bram_addr=0; bram_din=0; latency counter=0.
- Reset mid-transaction drops the in-flight request. Reset has priority over every other event.
- All outputs are registered except req_ready, which is 1 exactly when state==IDLE.

State machine: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE: a handshake (req_valid && req_ready) at edge T latches the request.
  - Fault if any of: address outside the window; req_re=1 with req_we!=0; req_re=0 with req_we=0.
  - Fault -> RESP directly, with resp_fault=1 and resp_rdata=0. No BRAM access occurs.
  - Otherwise -> ISSUE.
- ISSUE (cycle T+1): bram_en=1, bram_addr set, bram_we=req_we for a write (0 for a read), bram_din=req_wdata.
  - Write -> RESP, with resp_rdata=0 and resp_fault=0.
  - Read -> RD_WAIT, with counter loaded to READ_LATENCY-1.
- RD_WAIT: bram_en=0, bram_we=0. The counter decrements each cycle.
  - When the counter is 0, capture bram_dout into resp_rdata and go to RESP.
  - This capture is at end of cycle T+1+READ_LATENCY.
- RESP: resp_valid=1. resp_rdata and resp_fault are held stable until resp_ready.
  - On resp_valid && resp_ready -> IDLE; resp_valid drops next cycle.
- Latency from accept edge to first resp_valid cycle: write 2 cycles; read READ_LATENCY+2 cycles; fault 1 cycle.
- No pipelining: one outstanding transaction. A new request is accepted no earlier than the cycle after the response handshake.
- bram_we is non-zero for exactly one cycle per write. bram_en is high for exactly one cycle per legal access.
- req_* inputs are ignored outside IDLE and may change freely.
- Window check: req_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. The top word address (all ones) is legal, and there is no wrap into the next window.

Decomposition:
- Shared package (mem_pkg): the state enum (IDLE/ISSUE/RD_WAIT/RESP); the byte-enable constants WE_NONE=4'b0000 and WE_WORD=4'b1111; the default ADDR_W and BASE_ADDR.
- One natural sub-module: dmem_window_check, combinational. It takes the address and request fields and outputs fault, so the decode is reusable for a future MMIO decoder.
- The BRAM itself is external, a behavioural model in the bench.

Test Plan:
- Write word, then read back: write addr 0x10, we=1111, wdata 0xDEADBEEF, then read addr 0x10.
  - bram_we=1111 and bram_addr=4 for one cycle.
  - Write resp 2 cycles after accept.
  - Read resp_rdata=0xDEADBEEF, resp_valid 4 cycles after accept (READ_LATENCY=2).
- Byte-lane merge: pre-load 0x11223344 at addr 0x20, then write we=0100, wdata 0x00AB0000.
  - Subsequent read returns 0x11AB3344.
  - bram_din=0x00AB0000 during the write ISSUE cycle.
- Out of window: read at 0x0001_0000 (ADDR_W=12).
  - resp_fault=1 and resp_rdata=0, 1 cycle after accept.
  - bram_en stays 0 throughout.
  - Also: req_re=1 with req_we=0011 -> fault.
- Response backpressure: read with resp_ready held 0 for 5 cycles.
  - resp_valid, resp_rdata and resp_fault are stable for all 5 cycles.
  - req_ready=0 throughout, and a req_valid pulse during the hold is not accepted.
  - After resp_ready=1: IDLE next cycle, and a new request is accepted.
- Reset mid-read: assert rst in the RD_WAIT cycle.
  - Next cycle: req_ready=1, resp_valid=0, bram_en=0.
  - No response is ever produced for the dropped read.
- Top-of-window and latency sweep: read word address 0xFFF (byte 0x3FFC) is legal.
  - Repeat the read with READ_LATENCY=1 and 4: resp_valid arrives 3 and 6 cycles after accept respectively.
